// File: rtl/nabu_video_timing.sv
// TMS9918A-geometry raster timing (342 dots x 262/313 lines) with a built-in
// test-pattern source; the position counters double as the future VDP timebase.
module nabu_video_timing #(
    parameter int          CE_DIV    = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       pal,
    input  logic [1:0] mode,
    output logic       ce_pix,
    output logic       hsync,
    output logic       vsync,
    output logic       hblank,
    output logic       vblank,
    output logic [8:0] hcount,
    output logic [8:0] vcount,
    output logic [7:0] video
);

    localparam int               DIV_W    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);

    logic [DIV_W-1:0] div;
    logic             pal_q;
    logic [15:0]      lfsr;

    logic             h_last;
    logic             v_last;
    logic [8:0]       h_nxt;
    logic [8:0]       v_nxt;
    logic             active_nxt;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [7:0] pattern(input logic [1:0] m, input logic [8:0] h,
                                           input logic [15:0] s);
        logic [7:0] p;
        case (m)
            2'd0:    p = s[15:8];
            2'd1:    p = h[7:0];
            2'd2:    p = h[5] ? 8'hFF : 8'h00;
            default: p = 8'h80;
        endcase
        return p;
    endfunction

    // Next raster position; every registered strobe is decoded from it so
    // the outputs and the counters always describe the same dot.
    always_comb begin
        h_last     = (hcount == 9'd341);
        v_last     = (vcount == (pal_q ? 9'd312 : 9'd261));
        h_nxt      = h_last ? 9'd0 : hcount + 9'd1;
        v_nxt      = vcount;
        if (h_last) begin
            v_nxt = v_last ? 9'd0 : vcount + 9'd1;
        end
        active_nxt = (h_nxt < 9'd256) && (v_nxt < 9'd192);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            div    <= '0;
            ce_pix <= 1'b0;
            hcount <= 9'd0;
            vcount <= 9'd0;
            pal_q  <= 1'b0;
            lfsr   <= LFSR_SEED;
            hsync  <= 1'b0;
            vsync  <= 1'b0;
            hblank <= 1'b0;
            vblank <= 1'b0;
            video  <= 8'h00;
        end else begin
            div    <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
            ce_pix <= (div == DIV_LAST);
            if (ce_pix) begin
                hcount <= h_nxt;
                vcount <= v_nxt;
                // The NTSC/PAL choice is frozen for a whole frame.
                if (h_last && v_last) begin
                    pal_q <= pal;
                end
                hblank <= (h_nxt >= 9'd256);
                hsync  <= (h_nxt >= 9'd280) && (h_nxt <= 9'd305);
                vblank <= (v_nxt >= 9'd192);
                vsync  <= pal_q ? ((v_nxt >= 9'd244) && (v_nxt <= 9'd246))
                                : ((v_nxt >= 9'd216) && (v_nxt <= 9'd218));
                if (active_nxt) begin
                    video <= pattern(mode, h_nxt, lfsr);
                    lfsr  <= lfsr_step(lfsr);
                end else begin
                    video <= 8'h00;
                end
            end
        end
    end

endmodule

// File: tb/tb_nabu_video_timing.sv
// Bench for nabu_video_timing: frame-position reference model compared every
// cycle, plus literal checks on reset, first dots, sync widths and frame lengths.
module tb_nabu_video_timing;

    localparam int          CD   = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       pal;
    logic [1:0] mode;
    logic       ce_pix, hsync, vsync, hblank, vblank;
    logic [8:0] hcount, vcount;
    logic [7:0] video;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rand_en = 1'b0;
    bit done    = 1'b0;

    nabu_video_timing #(.CE_DIV(CD), .LFSR_SEED(SEED)) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .pal    (pal),
        .mode   (mode),
        .ce_pix (ce_pix),
        .hsync  (hsync),
        .vsync  (vsync),
        .hblank (hblank),
        .vblank (vblank),
        .hcount (hcount),
        .vcount (vcount),
        .video  (video)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc++;

    // Reference model: clock count since release -> dot count -> frame position.
    int          k     = 0;
    int          fdot  = 0;
    int          lines = 262;
    int          m_h   = 0;
    int          m_v   = 0;
    logic [15:0] m_lfsr = SEED;
    logic        m_ce = 0, m_hs = 0, m_vs = 0, m_hb = 0, m_vb = 0;
    logic [7:0]  m_video = 0;

    function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
        return (s >> 1) ^ ((s % 2) ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk_sys) begin
        if (!reset_n) begin
            k = 0; fdot = 0; lines = 262; m_h = 0; m_v = 0; m_lfsr = SEED;
            m_ce = 0; m_hs = 0; m_vs = 0; m_hb = 0; m_vb = 0; m_video = 0;
        end else begin
            k++;
            if (k > CD && (k - 1) % CD == 0) begin
                fdot++;
                if (fdot == 342 * lines) begin
                    fdot  = 0;
                    lines = pal ? 313 : 262;
                end
                m_h  = fdot % 342;
                m_v  = fdot / 342;
                m_hb = (m_h >= 256);
                m_hs = (m_h >= 280) && (m_h < 280 + 26);
                m_vb = (m_v >= 192);
                m_vs = (lines == 313) ? (m_v >= 244 && m_v < 247) : (m_v >= 216 && m_v < 219);
                if (!m_hb && !m_vb) begin
                    case (mode)
                        2'd0:    m_video = m_lfsr[15:8];
                        2'd1:    m_video = 8'(m_h % 256);
                        2'd2:    m_video = ((m_h / 32) % 2 == 1) ? 8'hFF : 8'h00;
                        default: m_video = 8'h80;
                    endcase
                    m_lfsr = ref_lfsr(m_lfsr);
                end else begin
                    m_video = 8'h00;
                end
            end
            m_ce = (k % CD == 0);
        end
    end

    task automatic finish_run();
        if (!done) begin
            done = 1'b1;
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    endtask

    always @(negedge clk_sys) begin
        logic [30:0] act;
        logic [30:0] exp;
        if (!done) begin
            act = {ce_pix, hsync, vsync, hblank, vblank, hcount, vcount, video};
            exp = reset_n ? {m_ce, m_hs, m_vs, m_hb, m_vb, 9'(m_h), 9'(m_v), m_video} : 31'd0;
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL model_cmp cyc=%0d got %h want %h", cyc, act, exp);
                if (errors >= 40) finish_run();
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return hsync;
            1:       return vsync;
            2:       return hblank;
            3:       return vblank;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_edge(input int sel, input bit rise, input int budget, output int t);
        logic prev;
        logic cur;
        int   n;
        prev = pick(sel);
        n    = 0;
        t    = 0;
        forever begin
            @(negedge clk_sys);
            n++;
            cur = pick(sel);
            if (cur == rise && prev != rise) begin
                t = cyc;
                break;
            end
            prev = cur;
            if (n > budget) begin
                checks++;
                errors++;
                $display("FAIL wait_edge sel=%0d rise=%0d got timeout want edge", sel, rise);
                break;
            end
        end
    endtask

    task automatic wait_pos(input int v, input int h, input int budget);
        int n;
        n = 0;
        while (!(vcount == 9'(v) && hcount == 9'(h))) begin
            @(negedge clk_sys);
            n++;
            if (n > budget) begin
                checks++;
                errors++;
                $display("FAIL wait_pos got (%0d,%0d) want (%0d,%0d)", hcount, vcount, h, v);
                break;
            end
        end
    endtask

    initial begin
        mode = 2'd0;
        forever begin
            @(negedge clk_sys);
            #2;
            if (rand_en && $urandom_range(0, 299) == 0) mode = 2'($urandom_range(0, 3));
        end
    end

    initial begin
        int t0, t1, t2, t3;
        reset_n = 1'b0;
        pal     = 1'b0;
        repeat (10) @(negedge clk_sys);
        check("reset_outputs", {ce_pix, hsync, vsync, hblank, vblank, hcount, vcount, video}, 0);
        #2 reset_n = 1'b1;

        @(posedge clk_sys); #1 check("ce_before_first", ce_pix, 0);
        @(posedge clk_sys); #1 check("ce_first", ce_pix, 1);
        @(posedge clk_sys); #1;
        check("ce_width", ce_pix, 0);
        check("pos_first", {hcount, vcount}, {9'd1, 9'd0});
        check("noise_dot1", video, 8'hAC);
        check("model_lfsr", m_lfsr, 16'hE270);
        repeat (CD) @(posedge clk_sys);
        #1 check("noise_dot2", video, 8'hE2);

        @(negedge clk_sys);
        rand_en = 1'b1;
        wait_edge(2, 1, 2000, t0);
        check("hblank_rise_h", hcount, 256);
        wait_edge(0, 1, 2000, t1);
        check("hsync_rise_h", hcount, 280);
        check("hsync_after_hblank", t1 - t0, 24 * CD);
        wait_edge(0, 0, 2000, t2);
        check("hsync_width", t2 - t1, 26 * CD);
        check("hsync_fall_h", hcount, 306);
        wait_edge(0, 1, 2000, t3);
        check("line_len", t3 - t1, 342 * CD);

        wait_pos(100, 0, 400000);
        #2 pal = 1'b1;
        wait_edge(3, 1, 400000, t0);
        check("vblank_rise", {hcount, vcount}, {9'd0, 9'd192});
        wait_edge(1, 1, 400000, t1);
        check("vsync_ntsc_rise", {hcount, vcount}, {9'd0, 9'd216});
        wait_edge(1, 0, 400000, t2);
        check("vsync_ntsc_fall", vcount, 219);
        wait_edge(1, 1, 400000, t3);
        check("vsync_pal_rise", vcount, 244);
        check("vsync_ntsc_to_pal", t3 - t1, 290 * 342 * CD);
        wait_edge(1, 0, 400000, t2);
        check("vsync_pal_fall", vcount, 247);

        wait_pos(300, 300, 400000);
        #2 reset_n = 1'b0;
        #1 check("async_clear", {ce_pix, hsync, vsync, hblank, vblank, hcount, vcount, video}, 0);
        repeat (3) @(negedge clk_sys);
        #2 reset_n = 1'b1;
        pal = 1'b0;
        repeat (CD + 1) @(posedge clk_sys);
        #1 check("restart_pos", {hcount, vcount}, {9'd1, 9'd0});
        repeat (3 * 342 * CD) @(negedge clk_sys);
        finish_run();
    end

endmodule

// File: doc/nabu_video_timing.md
# nabu_video_timing

Raster timing and test-pattern source for the NABU core. It generates the pixel enable, sync and blanking strobes and an 8-bit luminance stream that drive `ce_pix`, `HSync`, `VSync`, `HBlank`, `VBlank` and `video` in `emu`. Geometry matches the TMS9918A: 342 dots per line, 256×192 active area, 262 lines for NTSC and 313 for PAL. It stands in for the VDP until the VDP exists, and its counters are reused by the VDP afterwards.

## Interface
Parameters:
- `CE_DIV`, default 4: `clk_sys` cycles per pixel, where `ce_pix` marks one cycle in each group of `CE_DIV`. Legal range 2–16.
- `LFSR_SEED`, default 16'hACE1: noise LFSR reset value. Must be nonzero.

Ports:
- `clk_sys` in 1: system clock. This is the only clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `pal` in 1: 0 selects NTSC (262 lines), 1 selects PAL (313 lines). Driven from `status[2]`.
- `mode` in 2: pattern select. 0 = noise, 1 = horizontal gradient, 2 = vertical bars, 3 = flat grey.
- `ce_pix` out 1: pixel enable, one `clk_sys` cycle wide.
- `hsync` out 1: horizontal sync, active-high.
- `vsync` out 1: vertical sync, active-high.
- `hblank` out 1: horizontal blanking.
- `vblank` out 1: vertical blanking.
- `hcount` out 9: current dot, 0–341.
- `vcount` out 9: current line, 0–261 (NTSC) or 0–312 (PAL).
- `video` out 8: luminance. Forced to 0 when blanked.

## Operation
- **Divider:** `div` counts 0..CE_DIV-1 and wraps. `ce_pix` is registered and is 1 in exactly the cycle after `div == CE_DIV-1`.
- **Position update:** all position state changes only on cycles where `ce_pix` = 1.
- **Horizontal counter:** `hcount` increments and wraps 341→0.
- **Vertical counter:** `vcount` increments on the `hcount` 341→0 wrap. It wraps to 0 after line `LAST` (261 NTSC, 312 PAL).
- **PAL latch:** `pal` is sampled into `pal_q` only when `vcount` wraps to 0 (frame start). A mid-frame change of `pal` takes effect from the next frame.
- **Horizontal decode:**
  - `hblank` = (`hcount` ≥ 256)
  - `hsync` = (280 ≤ `hcount` ≤ 305), i.e. 26 dots.
- **Vertical decode:**
  - `vblank` = (`vcount` ≥ 192)
  - NTSC: `vsync` = (216 ≤ `vcount` ≤ 218)
  - PAL: `vsync` = (244 ≤ `vcount` ≤ 246)
- **Coherence:** decode is computed from the next counter values and registered alongside the counters. In any cycle, `hcount`, `vcount`, the sync/blank strobes and `video` all describe the same dot.
- **Pattern, active dots only** (`!hblank && !vblank`):
  - mode 0: `video` = `lfsr[15:8]`.
  - mode 1: `video` = `hcount[7:0]`.
  - mode 2: `video` = `hcount[5]` ? 8'hFF : 8'h00.
  - mode 3: `video` = 8'h80.
- **Blanked dots:** `video` = 0.
- **LFSR:** 16-bit Galois, right-shift, tap mask 16'hB400. Update rule: `lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 0)`.
  - Advances once per active dot, on the same `ce_pix` that registers that dot's `video`.
  - Does not advance during blanking.
  - Advances in every mode, so switching to mode 0 resumes the sequence.
- **`mode` changes:** applied at the next `ce_pix`, with no latching.

## Timing
- **Reset values**, held while `reset_n` = 0:
  - `div`, `hcount`, `vcount` = 0
  - `pal_q` = 0
  - `lfsr` = `LFSR_SEED`
  - `ce_pix`, `hsync`, `vsync`, `hblank`, `vblank` = 0
  - `video` = 0
- **Reset release:** the first `ce_pix` occurs `CE_DIV` cycles after `reset_n` rises.
  - At that `ce_pix` the position advances to (1,0).
  - Position (0,0) is shown with `video` = 0 for the first frame only.
- **Reset mid-frame:** everything returns to the reset values asynchronously, with no partial line emitted afterwards.
- **Output registration:** all outputs are registered and change only in the cycle after `ce_pix` is sampled high. They are stable for `CE_DIV` cycles.
- **Line and frame lengths:**
  - One line = 342 `ce_pix` = 342·`CE_DIV` `clk_sys` cycles.
  - NTSC frame = 262 lines; PAL frame = 313 lines.
- **Sync widths:**
  - `hsync` is high for 26 consecutive `ce_pix` per line.
  - `vsync` is high for 3 lines, i.e. 1026 `ce_pix`.
- **Sync edges:**
  - `hsync` rises 24 dots after `hblank` rises.
  - `vsync` rises on the line edge where `hcount` becomes 0.

## Test plan
1. **Reset:** hold `reset_n` = 0 for 10 cycles → every output reads 0 and `lfsr` = 16'hACE1. Release → `ce_pix` pulses at cycle 4, then every 4 cycles, each pulse 1 cycle wide.
2. **Horizontal:** NTSC, mode 1 → per line:
   - `hblank` rises at `hcount` = 256; `hsync` spans 280–305.
   - `video` = `hcount[7:0]` on active dots and 0 from dot 256.
   - The line is 1368 `clk_sys` cycles long.
3. **Vertical NTSC:** run 2 frames →
   - `vcount` wraps 261→0.
   - `vblank` covers lines 192–261.
   - `vsync` covers lines 216–218.
   - The frame is 262×1368 cycles long.
4. **PAL switch:** set `pal` = 1 at line 100 of an NTSC frame →
   - The current frame still wraps after line 261.
   - The next frame wraps after 312, with `vsync` on lines 244–246.
5. **Noise:** mode 0 from reset →
   - After the first active-dot advance, `lfsr` = 16'hE270.
   - `lfsr` is unchanged across the 86 blanked dots of each line.
   - `video` = 0 whenever `hblank` or `vblank` = 1.
6. **Mid-frame reset:** assert `reset_n` = 0 at dot 300 of line 150 → outputs clear within the same cycle. After release, counting restarts from (0,0) with the NTSC/PAL latch = 0.
